// File: rtl/spi_slave_param_if.sv
// SPI slave bus bundle: serial pins, RAM-side rx/tx data and error pulses.
// Latency: none, wires only.
// Backpressure: none; tx_valid is the only RAM-side qualifier into the slave.
interface spi_slave_param_if #(
   parameter int PAYLOAD_W = 8
);
   logic                 SS_n;
   logic                 MOSI;
   logic                 MISO;
   logic [PAYLOAD_W+1:0] rx_data;
   logic                 rx_valid;
   logic [PAYLOAD_W-1:0] tx_data;
   logic                 tx_valid;
   logic                 frame_err;
   logic                 cmd_err;

   // Slave side: the SPI front-end itself
   modport slave (
      input  SS_n, MOSI, tx_data, tx_valid,
      output MISO, rx_data, rx_valid, frame_err, cmd_err
   );

   // Master side: SPI host plus RAM model
   modport master (
      output SS_n, MOSI, tx_data, tx_valid,
      input  MISO, rx_data, rx_valid, frame_err, cmd_err
   );
endinterface

// File: rtl/spi_slave_param.sv
// SPI slave front-end: deserialises {cmd[1:0], payload} frames and serialises RAM read data.
// Latency: rx_valid one edge after the last frame bit; MISO MSB one edge after tx_valid in WAIT_TX.
// Backpressure: none on rx; WAIT_TX stalls for tx_valid up to TX_TIMEOUT cycles (0 = forever).
module spi_slave_param #(
   parameter int PAYLOAD_W      = 8,
   parameter int TX_TIMEOUT     = 16,
   parameter bit ENFORCE_RD_ORD = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   spi_slave_param_if.slave  bus
);
   localparam int FRAME_W = PAYLOAD_W + 2;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam int TO_W    = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;

   localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(PAYLOAD_W);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_W);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TX_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, RECV, WAIT_TX, TX, HOLD} state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [TO_W-1:0]      to_cnt;
   logic [FRAME_W-2:0]   shreg;
   logic [PAYLOAD_W-1:0] txsh;
   logic                 rd_addr_seen;
   logic                 miso;
   logic [FRAME_W-1:0]   rx_data;
   logic                 rx_valid;
   logic                 frame_err;
   logic                 cmd_err;

   // The frame as it stands once the current MOSI bit is shifted in
   logic [FRAME_W-1:0]   frame;
   logic [1:0]           cmd;
   assign frame = {shreg, bus.MOSI};
   assign cmd   = frame[FRAME_W-1 -: 2];

   assign bus.MISO      = miso;
   assign bus.rx_data   = rx_data;
   assign bus.rx_valid  = rx_valid;
   assign bus.frame_err = frame_err;
   assign bus.cmd_err   = cmd_err;

   // Frame FSM: receive, command decode, read-data turnaround and serial transmit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         to_cnt       <= '0;
         shreg        <= '0;
         txsh         <= '0;
         rd_addr_seen <= 1'b0;
         miso         <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
         cmd_err      <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         cmd_err   <= 1'b0;
         case (state)
            IDLE: begin
               miso <= 1'b0;
               // The select edge itself carries no data bit
               if (!bus.SS_n) begin
                  state <= RECV;
                  cnt   <= '0;
               end
            end
            RECV: begin
               if (bus.SS_n) begin
                  // Deselect wins over a frame completing on the same edge
                  state     <= IDLE;
                  miso      <= 1'b0;
                  frame_err <= 1'b1;
               end else begin
                  shreg <= frame[FRAME_W-2:0];
                  if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST_RX) begin
                     if (cmd == 2'b11 && ENFORCE_RD_ORD && !rd_addr_seen) begin
                        // Read-data with no read-address: drop the frame
                        cmd_err <= 1'b1;
                        state   <= HOLD;
                     end else begin
                        rx_data  <= frame;
                        rx_valid <= 1'b1;
                        if (cmd == 2'b11) begin
                           state  <= WAIT_TX;
                           to_cnt <= '0;
                        end else begin
                           state <= HOLD;
                           if (cmd == 2'b10) rd_addr_seen <= 1'b1;
                        end
                     end
                  end
               end
            end
            WAIT_TX: begin
               if (bus.SS_n) begin
                  state     <= IDLE;
                  miso      <= 1'b0;
                  frame_err <= 1'b1;
               end else if (bus.tx_valid) begin
                  // MSB goes out now; the rest shifts out of txsh in TX
                  miso  <= bus.tx_data[PAYLOAD_W-1];
                  txsh  <= bus.tx_data << 1;
                  cnt   <= CNT_W'(1);
                  state <= TX;
               end else if (TX_TIMEOUT > 0 && to_cnt == TO_LAST) begin
                  frame_err <= 1'b1;
                  state     <= HOLD;
               end else if (to_cnt != '1) begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            TX: begin
               if (bus.SS_n) begin
                  state     <= IDLE;
                  miso      <= 1'b0;
                  frame_err <= 1'b1;
               end else if (cnt == LAST_TX) begin
                  // LSB has had its full cycle on the wire
                  miso         <= 1'b0;
                  rd_addr_seen <= 1'b0;
                  state        <= HOLD;
               end else begin
                  miso <= txsh[PAYLOAD_W-1];
                  txsh <= txsh << 1;
                  cnt  <= cnt + CNT_W'(1);
               end
            end
            HOLD: begin
               miso <= 1'b0;
               if (bus.SS_n) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               miso  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: two instances differing only in read-order enforcement.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-computed constants per vector.
module tb_spi_slave_param;
   logic       clk;
   logic       rst;
   logic       ss_n;
   logic       mosi;
   logic [7:0] tx_data;
   logic       tx_valid;

   int n_checks = 0;
   int n_errors = 0;

   spi_slave_param_if #(.PAYLOAD_W(8)) ifa ();
   spi_slave_param_if #(.PAYLOAD_W(8)) ifb ();

   assign ifa.SS_n     = ss_n;
   assign ifa.MOSI     = mosi;
   assign ifa.tx_data  = tx_data;
   assign ifa.tx_valid = tx_valid;
   assign ifb.SS_n     = ss_n;
   assign ifb.MOSI     = mosi;
   assign ifb.tx_data  = tx_data;
   assign ifb.tx_valid = tx_valid;

   spi_slave_param #(.PAYLOAD_W(8), .TX_TIMEOUT(16), .ENFORCE_RD_ORD(1'b1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   spi_slave_param #(.PAYLOAD_W(8), .TX_TIMEOUT(16), .ENFORCE_RD_ORD(1'b0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Select, shift n bits MSB first, return at the falling edge after the n-th sampling edge
   task automatic send_frame(input logic [9:0] f, input int n, output int early);
      early = 0;
      @(negedge clk);
      ss_n = 1'b0;
      mosi = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (ifa.rx_valid) early++;
         mosi = f[9-i];
      end
      @(negedge clk);
   endtask

   task automatic end_frame();
      @(negedge clk);
      ss_n = 1'b1;
      mosi = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int early;
      int bad;
      logic [7:0] pat;

      rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_data = '0; tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_miso",      ifa.MISO,      0);
      check("rst_rx_data",   ifa.rx_data,   0);
      check("rst_rx_valid",  ifa.rx_valid,  0);
      check("rst_frame_err", ifa.frame_err, 0);
      check("rst_cmd_err",   ifa.cmd_err,   0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Write-address frame 00_1010_0101
      send_frame(10'h0A5, 10, early);
      check("wa_early_valid", early,        0);
      check("wa_rx_valid",    ifa.rx_valid, 1);
      check("wa_rx_data",     ifa.rx_data,  10'h0A5);
      @(negedge clk);
      check("wa_valid_pulse", ifa.rx_valid, 0);
      end_frame();

      // Asynchronous reset in the middle of a frame
      @(negedge clk);
      ss_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mosi = 1'b1;
      end
      #2 rst = 1'b1;
      #1;
      check("arst_rx_data",   ifa.rx_data,   0);
      check("arst_miso",      ifa.MISO,      0);
      check("arst_rx_valid",  ifa.rx_valid,  0);
      check("arst_frame_err", ifa.frame_err, 0);
      ss_n = 1'b1;
      mosi = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (ifa.rx_valid || ifa.frame_err) bad++;
      end
      check("arst_quiet_after", bad, 0);

      // Read-address then read-data with tx_data C3 ready
      send_frame(10'h23C, 10, early);
      check("ra_rx_valid", ifa.rx_valid, 1);
      check("ra_rx_data",  ifa.rx_data,  10'h23C);
      end_frame();
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      send_frame(10'h3FF, 10, early);
      check("rd_rx_valid", ifa.rx_valid, 1);
      check("rd_rx_data",  ifa.rx_data,  10'h3FF);
      check("rd_miso_pre", ifa.MISO,     0);
      pat = 8'hC3;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check($sformatf("tx_bit%0d", 7 - j), ifa.MISO, pat[7-j]);
      end
      @(negedge clk);
      check("tx_after_lsb", ifa.MISO, 0);
      tx_valid = 1'b0;
      end_frame();

      // Read-data with no prior read-address, both ordering modes
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      send_frame(10'h300, 10, early);
      check("ord_a_cmd_err",  ifa.cmd_err,  1);
      check("ord_a_rx_valid", ifa.rx_valid, 0);
      check("ord_a_rx_data",  ifa.rx_data,  0);
      check("ord_b_rx_valid", ifb.rx_valid, 1);
      check("ord_b_rx_data",  ifb.rx_data,  10'h300);
      check("ord_b_cmd_err",  ifb.cmd_err,  0);
      tx_data  = 8'h81;
      tx_valid = 1'b1;
      @(negedge clk);
      check("ord_a_cmd_pulse", ifa.cmd_err, 0);
      check("ord_b_wait_tx",   ifb.MISO,    1);
      check("ord_a_hold_miso", ifa.MISO,    0);
      @(negedge clk);
      check("ord_b_bit6", ifb.MISO, 0);
      tx_valid = 1'b0;
      end_frame();
      check("ord_a_hold_exit", ifa.frame_err, 0);

      // Deselect after 5 payload bits
      send_frame(10'h1F0, 10, early);
      check("ab_setup_data", ifa.rx_data, 10'h1F0);
      end_frame();
      @(negedge clk);
      ss_n = 1'b0;
      pat = 8'h55;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         mosi = pat[i];
      end
      @(negedge clk);
      ss_n = 1'b1;
      @(negedge clk);
      check("ab_frame_err", ifa.frame_err, 1);
      check("ab_rx_valid",  ifa.rx_valid,  0);
      check("ab_rx_data",   ifa.rx_data,   10'h1F0);
      @(negedge clk);
      check("ab_err_pulse", ifa.frame_err, 0);
      send_frame(10'h05A, 10, early);
      check("ab_next_valid", ifa.rx_valid, 1);
      check("ab_next_data",  ifa.rx_data,  10'h05A);
      end_frame();

      // Read-data with tx_valid held low: timeout after 16 cycles in WAIT_TX
      send_frame(10'h201, 10, early);
      end_frame();
      send_frame(10'h300, 10, early);
      check("to_rx_valid", ifa.rx_valid, 1);
      bad = 0;
      for (int j = 1; j < 16; j++) begin
         @(negedge clk);
         if (ifa.frame_err || ifa.MISO) bad++;
      end
      check("to_early", bad, 0);
      @(negedge clk);
      check("to_frame_err", ifa.frame_err, 1);
      check("to_miso",      ifa.MISO,      0);
      @(negedge clk);
      check("to_err_pulse", ifa.frame_err, 0);
      end_frame();
      check("to_hold_exit", ifa.frame_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
